axi_write_burst: RTL and testbench

//  Stream-to-AXI4 burst writer; the stage directly upstream of axi_read.

---
 rtl/axi_write_burst.sv | 207 ++++++++++++++++++++
 tb/tb_axi_write_burst.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_burst.sv
// Stream-to-AXI4 burst writer: collects WR_LEN stream beats into a local buffer,
// then writes them as one INCR burst and pulses o_wr_done on the B response.
module axi_write_burst #(
  parameter int              WR_FLIP_BYTE  = 0,
  parameter int              WR_ADDR_WIDTH = 32,
  parameter int              WR_DATA_WIDTH = 64,
  parameter int              WR_LEN        = 16,
  parameter longint unsigned WR_BASE_ADDR  = 0,
  parameter longint unsigned WR_ADDR_STEP  = 4096,
  parameter longint unsigned WR_ADDR_RANGE = 'h10000
) (
  input  logic                         S_WR_aclk,
  input  logic                         S_WR_areset,
  input  logic [WR_DATA_WIDTH-1:0]     S_WR_tdata,
  input  logic                         S_WR_tvalid,
  output logic                         S_WR_tready,
  input  logic                         S_WR_tlast,
  output logic                         o_wr_done,
  output logic                         o_wr_err,
  output logic                         m_axi_awid,
  output logic [WR_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awlock,
  output logic [3:0]                   m_axi_awcache,
  output logic [2:0]                   m_axi_awprot,
  output logic [3:0]                   m_axi_awqos,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [WR_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [WR_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic                         m_axi_bid,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready
);
  localparam int DW  = WR_DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int AIW = (WR_LEN > 1) ? $clog2(WR_LEN) : 1;
  localparam logic [8:0] LEN9  = 9'(WR_LEN);
  localparam logic [8:0] LAST9 = 9'(WR_LEN - 1);
  localparam logic [WR_ADDR_WIDTH-1:0] BASE_A = WR_ADDR_WIDTH'(WR_BASE_ADDR);
  localparam logic [WR_ADDR_WIDTH-1:0] STEP_A = WR_ADDR_WIDTH'(WR_ADDR_STEP);
  localparam logic [WR_ADDR_WIDTH-1:0] LAST_A =
    WR_ADDR_WIDTH'(WR_BASE_ADDR + WR_ADDR_RANGE - WR_ADDR_STEP);

  typedef enum logic [2:0] {FILL, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;

  state_t                     state_q, state_d;
  logic [8:0]                 cnt_q, cnt_d, nbeats_q, nbeats_d, beat_q, beat_d;
  logic [WR_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic tready_q, tready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic wlast_q, wlast_d, pad_q, pad_d, bready_q, bready_d;
  logic done_q, done_d, err_q, err_d;

  logic [DW-1:0]  flipped, beat_in, rdata_q;
  logic [DW-1:0]  mem [WR_LEN];
  logic           mem_we, mem_re;
  logic [AIW-1:0] mem_waddr, mem_raddr;
  logic [8:0]     nxt_beat, cnt_inc;
  logic           s_hs, aw_hs, w_hs, b_hs, unused_bid;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_flip
      assign flipped[gi*8 +: 8] = S_WR_tdata[DW-8-gi*8 +: 8];
    end
  endgenerate
  assign beat_in = (WR_FLIP_BYTE != 0) ? flipped : S_WR_tdata;

  assign s_hs      = S_WR_tvalid & tready_q;
  assign aw_hs     = awvalid_q & m_axi_awready;
  assign w_hs      = wvalid_q & m_axi_wready;
  assign b_hs      = bready_q & m_axi_bvalid;
  assign cnt_inc   = cnt_q + 9'd1;
  assign nxt_beat  = beat_q + 9'd1;
  assign mem_waddr = cnt_q[AIW-1:0];
  assign mem_raddr = aw_hs ? '0 : nxt_beat[AIW-1:0];

  // Registered-read buffer; the read port only advances on a W handshake so
  // wdata holds through wready stalls.
  always_ff @(posedge S_WR_aclk) begin
    if (mem_we) mem[mem_waddr] <= beat_in;
    if (mem_re) rdata_q <= mem[mem_raddr];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbeats_d = nbeats_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wlast_d  = wlast_q;
    pad_d    = pad_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_hs) begin
          mem_we = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == LEN9 || S_WR_tlast) begin
            nbeats_d = cnt_inc;
            state_d  = WR_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (aw_hs) begin
          state_d = WR_DATA;
          mem_re  = 1'b1;
          beat_d  = 9'd0;
          pad_d   = 1'b0;
          wlast_d = (LAST9 == 9'd0);
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          if (wlast_q) begin
            state_d = WR_RESP;
            wlast_d = 1'b0;
          end else begin
            mem_re  = 1'b1;
            beat_d  = nxt_beat;
            pad_d   = (nxt_beat >= nbeats_q);
            wlast_d = (nxt_beat == LAST9);
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = 9'd0;
        addr_d  = (addr_q >= LAST_A) ? BASE_A : addr_q + STEP_A;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    // Handshake outputs are registered copies of the next state
    tready_d  = (state_d == FILL);
    awvalid_d = (state_d == WR_ADDR);
    wvalid_d  = (state_d == WR_DATA);
    bready_d  = (state_d == WR_RESP);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge S_WR_aclk or posedge S_WR_areset) begin
    if (S_WR_areset) begin
      state_q   <= FILL;
      cnt_q     <= 9'd0;
      nbeats_q  <= 9'd0;
      beat_q    <= 9'd0;
      addr_q    <= BASE_A;
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      pad_q     <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nbeats_q  <= nbeats_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      tready_q  <= tready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      pad_q     <= pad_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign unused_bid    = m_axi_bid;
  assign S_WR_tready   = tready_q;
  assign o_wr_done     = done_q;
  assign o_wr_err      = err_q;
  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(WR_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(NB));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd3;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = pad_q ? '0 : rdata_q;
  assign m_axi_wstrb   = pad_q ? '0 : {NB{1'b1}};
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_write_burst.sv
// Directed bench for axi_write_burst: a plain instance and a byte-flipping
// instance share all inputs; stream, AW, W and B phases are driven in sequence.
module tb_axi_write_burst;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tvalid, tlast, awready, wready, bid, bvalid;
  logic [63:0] tdata;
  logic [1:0]  bresp;

  logic        tready, done, err, awid, awlock, awvalid, wlast, wvalid, bready;
  logic [31:0] awaddr;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic [63:0] wdata;

  logic        f_tready, f_done, f_err, f_awid, f_awlock, f_awvalid, f_wlast, f_wvalid, f_bready;
  logic [31:0] f_awaddr;
  logic [7:0]  f_awlen, f_wstrb;
  logic [2:0]  f_awsize, f_awprot;
  logic [1:0]  f_awburst;
  logic [3:0]  f_awcache, f_awqos;
  logic [63:0] f_wdata;

  axi_write_burst #(.WR_FLIP_BYTE(0)) dut (
    .S_WR_aclk(clk), .S_WR_areset(rst), .S_WR_tdata(tdata), .S_WR_tvalid(tvalid),
    .S_WR_tready(tready), .S_WR_tlast(tlast), .o_wr_done(done), .o_wr_err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  axi_write_burst #(.WR_FLIP_BYTE(1)) dut_f (
    .S_WR_aclk(clk), .S_WR_areset(rst), .S_WR_tdata(tdata), .S_WR_tvalid(tvalid),
    .S_WR_tready(f_tready), .S_WR_tlast(tlast), .o_wr_done(f_done), .o_wr_err(f_err),
    .m_axi_awid(f_awid), .m_axi_awaddr(f_awaddr), .m_axi_awlen(f_awlen),
    .m_axi_awsize(f_awsize), .m_axi_awburst(f_awburst), .m_axi_awlock(f_awlock),
    .m_axi_awcache(f_awcache), .m_axi_awprot(f_awprot), .m_axi_awqos(f_awqos),
    .m_axi_awvalid(f_awvalid), .m_axi_awready(awready), .m_axi_wdata(f_wdata),
    .m_axi_wstrb(f_wstrb), .m_axi_wlast(f_wlast), .m_axi_wvalid(f_wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(f_bready)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] pat [16];
  logic [31:0] exp_addr;
  logic        exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] bswap(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = v[56-8*k +: 8];
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int g;
    tdata = d; tvalid = 1'b1; tlast = last; g = 0;
    while (tready !== 1'b1 && g < 50) begin step(); g++; end
    chk("tready_wait", {63'b0, tready}, 64'd1);
    step();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic do_burst(input int nb, input int aw_dly, input bit toggle, input logic [1:0] resp);
    logic [63:0] ed;
    for (int i = 0; i < nb; i++) send_beat(pat[i], (i == nb - 1) && (nb < 16));
    chk("awvalid_lat", {63'b0, awvalid}, 64'd1);
    chk("tready_low", {63'b0, tready}, 64'd0);
    chk("awaddr", {32'b0, awaddr}, {32'b0, exp_addr});
    chk("f_awaddr", {32'b0, f_awaddr}, {32'b0, exp_addr});
    chk("awlen", {56'b0, awlen}, 64'd15);
    chk("awsize", {61'b0, awsize}, 64'd3);
    chk("awburst", {62'b0, awburst}, 64'd1);
    chk("awcache", {60'b0, awcache}, 64'd3);
    for (int d = 0; d < aw_dly; d++) begin
      step();
      chk("awvalid_hold", {63'b0, awvalid}, 64'd1);
      chk("awaddr_hold", {32'b0, awaddr}, {32'b0, exp_addr});
      chk("w_before_aw", {63'b0, wvalid}, 64'd0);
    end
    awready = 1'b1; step(); awready = 1'b0;
    chk("awvalid_fall", {63'b0, awvalid}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      ed = (i < nb) ? pat[i] : 64'd0;
      if (toggle) begin
        wready = 1'b0; step();
        chk("wvalid_stall", {63'b0, wvalid}, 64'd1);
        chk("wdata_stall", wdata, ed);
        chk("wlast_stall", {63'b0, wlast}, (i == 15) ? 64'd1 : 64'd0);
      end
      wready = 1'b1;
      chk("wvalid", {63'b0, wvalid}, 64'd1);
      chk("wdata", wdata, ed);
      chk("wstrb", {56'b0, wstrb}, (i < nb) ? 64'hFF : 64'h00);
      chk("wlast", {63'b0, wlast}, (i == 15) ? 64'd1 : 64'd0);
      chk("f_wdata", f_wdata, (i < nb) ? bswap(pat[i]) : 64'd0);
      step();
      wready = 1'b0;
    end
    chk("wvalid_end", {63'b0, wvalid}, 64'd0);
    chk("bready_early", {63'b0, bready}, 64'd1);
    bvalid = 1'b1; bresp = resp; step(); bvalid = 1'b0; bresp = 2'b00;
    if (resp != 2'b00) exp_err = 1'b1;
    chk("done_pulse", {63'b0, done}, 64'd1);
    chk("f_done_pulse", {63'b0, f_done}, 64'd1);
    chk("err", {63'b0, err}, {63'b0, exp_err});
    step();
    chk("done_low", {63'b0, done}, 64'd0);
    chk("tready_back", {63'b0, tready}, 64'd1);
    $display("burst addr=%h beats=%0d aw_dly=%0d toggle=%0d bresp=%0d err=%0d",
             exp_addr, nb, aw_dly, toggle, resp, err);
    exp_addr = (exp_addr >= 32'hF000) ? 32'h0 : exp_addr + 32'h1000;
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; awready = 1'b0;
    wready = 1'b0; bid = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    exp_addr = 32'h0; exp_err = 1'b0;
    step();
    chk("rst_tready", {63'b0, tready}, 64'd0);
    chk("rst_awvalid", {63'b0, awvalid}, 64'd0);
    chk("rst_wvalid", {63'b0, wvalid}, 64'd0);
    chk("rst_wlast", {63'b0, wlast}, 64'd0);
    chk("rst_bready", {63'b0, bready}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    rst = 1'b0; step();

    // 1) full burst, no stalls
    for (int i = 0; i < 16; i++) pat[i] = 64'(i);
    do_burst(16, 0, 1'b0, 2'b00);

    // 2) delayed awready, toggling wready
    for (int i = 0; i < 16; i++) pat[i] = 64'h100 + 64'(i);
    do_burst(16, 5, 1'b1, 2'b00);

    // 3) 17 back-to-back bursts from a fresh reset: address wraps after 0xF000
    rst = 1'b1; step(); rst = 1'b0; step();
    exp_addr = 32'h0; exp_err = 1'b0;
    for (int b = 0; b < 17; b++) begin
      for (int i = 0; i < 16; i++) pat[i] = 64'(b * 16 + i);
      do_burst(16, 0, 1'b0, 2'b00);
    end

    // 4) early tlast on beat 5
    for (int i = 0; i < 16; i++) pat[i] = 64'hA0 + 64'(i);
    do_burst(6, 0, 1'b0, 2'b00);

    // 5) error response then OKAY; error stays sticky
    do_burst(16, 0, 1'b0, 2'b10);
    do_burst(16, 0, 1'b0, 2'b00);
    chk("err_sticky", {63'b0, err}, 64'd1);

    // 6) reset in the middle of the W phase
    for (int i = 0; i < 16; i++) send_beat(64'h55 + 64'(i), 1'b0);
    awready = 1'b1; step(); awready = 1'b0;
    wready = 1'b1; step(); step(); step();
    rst = 1'b1; #1;
    chk("arst_tready", {63'b0, tready}, 64'd0);
    chk("arst_awvalid", {63'b0, awvalid}, 64'd0);
    chk("arst_wvalid", {63'b0, wvalid}, 64'd0);
    chk("arst_wlast", {63'b0, wlast}, 64'd0);
    chk("arst_bready", {63'b0, bready}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_err", {63'b0, err}, 64'd0);
    wready = 1'b0;
    step(); rst = 1'b0; step();
    exp_addr = 32'h0; exp_err = 1'b0;
    pat[0] = 64'h0102030405060708;
    do_burst(1, 0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
